// File: rtl/clkgate_ctrl_pkg.sv
// Shared types and helpers for the gated-clock branch sequencer.
// State encodings are visible on the state port, so keep them fixed.
package clkgate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Counter must hold the larger of the two reload values (value - 1),
    // plus one spare so a parameter of 1 still yields a 1-bit counter.
    function automatic int calc_cnt_w(input int wake_cyc, input int idle_cyc);
        int max_cyc;
        max_cyc = (wake_cyc > idle_cyc) ? wake_cyc : idle_cyc;
        return (max_cyc < 1) ? 1 : $clog2(max_cyc + 1);
    endfunction

endpackage

// File: rtl/clkgate_ctrl_cnt.sv
// Loadable down-counter that saturates at zero; used for both the wake-up
// settle interval and the idle hysteresis interval.
module clkgate_ctrl_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (dec && (count_reg != '0)) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/clkgate_ctrl.sv
// Sequences a shared gated-clock branch: enables the ICG on demand, waits for
// the tree to settle before granting, and holds the clock through idle gaps.
module clkgate_ctrl
    import clkgate_ctrl_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WAKE_CYC = 2,
    parameter int IDLE_CYC = 8
) (
    input  logic               clk,
    input  logic               rn,
    input  logic [NUM_REQ-1:0] req,
    input  logic               force_on,
    output logic [NUM_REQ-1:0] ack,
    output logic               clk_en,
    output logic [1:0]         state
);

    localparam int CNT_W = calc_cnt_w(WAKE_CYC, IDLE_CYC);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYC - 1);

    state_t             state_reg;
    state_t             state_next;
    logic               clk_en_reg;
    logic               clk_en_next;
    logic [NUM_REQ-1:0] ack_reg;
    logic [NUM_REQ-1:0] ack_next;

    logic               demand;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_dec;
    logic               cnt_zero;

    assign demand = (|req) | force_on;

    clkgate_ctrl_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rn       (rn),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_next   = state_reg;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_reg)
            ST_OFF: begin
                if (demand) begin
                    state_next   = ST_WAKE;
                    cnt_load     = 1'b1;
                    cnt_load_val = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // Settle time is unconditional: a dropped demand still lands in
                // ON, which then falls through to HOLD on the next edge.
                if (cnt_zero) begin
                    state_next = ST_ON;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_ON: begin
                if (!demand) begin
                    state_next   = ST_HOLD;
                    cnt_load     = 1'b1;
                    cnt_load_val = IDLE_LOAD;
                end
            end
            ST_HOLD: begin
                // Demand outranks expiry so a late request never sees the clock drop.
                if (demand) begin
                    state_next = ST_ON;
                end else if (cnt_zero) begin
                    state_next = ST_OFF;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_next = ST_OFF;
            end
        endcase
    end

    assign clk_en_next = (state_next != ST_OFF);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
            assign ack_next[gi] = req[gi] & (state_next == ST_ON);
        end
    endgenerate

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            state_reg  <= ST_OFF;
            clk_en_reg <= 1'b0;
            ack_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            clk_en_reg <= clk_en_next;
            ack_reg    <= ack_next;
        end
    end

    assign ack    = ack_reg;
    assign clk_en = clk_en_reg;
    assign state  = state_reg;

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Directed bench for clkgate_ctrl (NUM_REQ=4, WAKE_CYC=2, IDLE_CYC=8) with
// hand-computed expectations after each rising edge.
module tb_clkgate_ctrl;

    logic       clk = 1'b0;
    logic       rn;
    logic [3:0] req;
    logic       force_on;
    logic [3:0] ack;
    logic       clk_en;
    logic [1:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    clkgate_ctrl #(
        .NUM_REQ  (4),
        .WAKE_CYC (2),
        .IDLE_CYC (8)
    ) dut (
        .clk      (clk),
        .rn       (rn),
        .req      (req),
        .force_on (force_on),
        .ack      (ack),
        .clk_en   (clk_en),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_checks++;
        if (obs === exp_val) begin
            n_pass++;
            $display("ok   %-24s obs=%0h exp=%0h", tag, obs, exp_val);
        end else begin
            $display("FAIL %-24s obs=%0h exp=%0h", tag, obs, exp_val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] st, input logic en, input logic [3:0] ak);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".clk_en"}, 32'(clk_en), 32'(en));
        check({tag, ".ack"}, 32'(ack), 32'(ak));
    endtask

    // Async reset pulse between edges, then release with req held and
    // expect the full wake sequence again.
    task automatic reset_mid_cycle(input string tag);
        #2 rn = 1'b0;
        #1 check_out({tag, "_rst"}, 2'd0, 1'b0, 4'b0000);
        step();
        check_out({tag, "_rst_held"}, 2'd0, 1'b0, 4'b0000);
        rn = 1'b1;
        step();
        check_out({tag, "_e0"}, 2'd1, 1'b1, 4'b0000);
        step();
        check_out({tag, "_e1"}, 2'd1, 1'b1, 4'b0000);
        step();
        check_out({tag, "_e2"}, 2'd2, 1'b1, 4'b0001);
    endtask

    initial begin
        rn       = 1'b0;
        req      = 4'b0000;
        force_on = 1'b0;
        step();
        step();
        check_out("reset", 2'd0, 1'b0, 4'b0000);
        rn = 1'b1;
        step();
        check_out("idle_off", 2'd0, 1'b0, 4'b0000);

        // Cold wake: ACK exactly two edges after CLK_EN rises
        req = 4'b0001;
        step();
        check_out("wake_e0", 2'd1, 1'b1, 4'b0000);
        step();
        check_out("wake_e1", 2'd1, 1'b1, 4'b0000);
        step();
        check_out("wake_e2", 2'd2, 1'b1, 4'b0001);

        // ACK follows REQ per requester while ON
        req = 4'b0011;
        step();
        check_out("on_add", 2'd2, 1'b1, 4'b0011);
        req = 4'b0010;
        step();
        check_out("on_drop0", 2'd2, 1'b1, 4'b0010);

        // Idle off: HOLD at edge k, OFF at edge k+8
        req = 4'b0000;
        step();
        check_out("hold_k", 2'd3, 1'b1, 4'b0000);
        for (int i = 1; i < 8; i++) step();
        check_out("hold_k7", 2'd3, 1'b1, 4'b0000);
        step();
        check_out("off_k8", 2'd0, 1'b0, 4'b0000);

        // REQ dropped during WAKE: ON without ACK, then HOLD
        req = 4'b0100;
        step();
        check_out("drop_e0", 2'd1, 1'b1, 4'b0000);
        req = 4'b0000;
        step();
        step();
        check_out("drop_e2", 2'd2, 1'b1, 4'b0000);
        step();
        check_out("drop_hold", 2'd3, 1'b1, 4'b0000);

        // HOLD re-arm with counter at 3 (4 edges after entering HOLD)
        for (int i = 0; i < 4; i++) step();
        check_out("rearm_c3", 2'd3, 1'b1, 4'b0000);
        req = 4'b0100;
        step();
        check_out("rearm", 2'd2, 1'b1, 4'b0100);

        // Boundary: demand on the edge where the counter would expire
        req = 4'b0000;
        step();
        check_out("bnd_hold", 2'd3, 1'b1, 4'b0000);
        for (int i = 0; i < 7; i++) step();
        check_out("bnd_c0", 2'd3, 1'b1, 4'b0000);
        req = 4'b1000;
        step();
        check_out("bnd_win", 2'd2, 1'b1, 4'b1000);

        // Drain to OFF, then FORCE_ON alone
        req = 4'b0000;
        for (int i = 0; i < 9; i++) step();
        check_out("pre_force", 2'd0, 1'b0, 4'b0000);
        force_on = 1'b1;
        req      = 4'b0000;
        step();
        check_out("force_e0", 2'd1, 1'b1, 4'b0000);
        step();
        step();
        check_out("force_on", 2'd2, 1'b1, 4'b0000);
        step();
        check_out("force_stay", 2'd2, 1'b1, 4'b0000);
        force_on = 1'b0;
        step();
        check_out("force_hold", 2'd3, 1'b1, 4'b0000);
        for (int i = 1; i < 8; i++) step();
        check_out("force_k7", 2'd3, 1'b1, 4'b0000);
        step();
        check_out("force_off", 2'd0, 1'b0, 4'b0000);

        // Async reset in WAKE, then in ON
        req = 4'b0001;
        step();
        check_out("pre_rst_wake", 2'd1, 1'b1, 4'b0000);
        reset_mid_cycle("rst_wake");
        reset_mid_cycle("rst_on");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
